// File: rtl/log_shift_pkg.sv
// Shared types and the behavioural reference shift for the logarithmic barrel shifter.
package log_shift_pkg;

  localparam int LS_DATA_W  = 32;
  localparam int LS_SHAMT_W = $clog2(LS_DATA_W);

  typedef enum logic [1:0] {
    SLL = 2'd0,
    SRL = 2'd1,
    SRA = 2'd2,
    ROL = 2'd3
  } shift_op_t;

  typedef struct packed {
    logic [LS_DATA_W-1:0]  data;
    logic [LS_SHAMT_W-1:0] shamt;
    shift_op_t             op;
    logic                  sign;
  } stage_pay_t;

  function automatic logic [LS_DATA_W-1:0] shift_ref(
    input logic [LS_DATA_W-1:0]  data,
    input logic [LS_SHAMT_W-1:0] shamt,
    input shift_op_t             op
  );
    logic [2*LS_DATA_W-1:0] rot;
    rot = {data, data} << shamt;
    case (op)
      SLL:     return data << shamt;
      SRL:     return data >> shamt;
      SRA:     return LS_DATA_W'($signed(data) >>> shamt);
      ROL:     return rot[2*LS_DATA_W-1 -: LS_DATA_W];
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/log_shift_stage.sv
// One barrel-shifter stage: optional shift by 2**STAGE_IDX, then a holdable payload register.
module log_shift_stage
  import log_shift_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SHAMT_W   = $clog2(DATA_W),
  parameter int STAGE_IDX = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_valid,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  shift_op_t          i_op,
  input  logic               i_sign,
  output logic               o_valid,
  output logic [DATA_W-1:0]  o_data,
  output logic [SHAMT_W-1:0] o_shamt,
  output shift_op_t          o_op,
  output logic               o_sign
);

  localparam int DIST = 1 << STAGE_IDX;

  logic [DATA_W-1:0]  w_shifted;
  logic               r_valid;
  logic [DATA_W-1:0]  r_data;
  logic [SHAMT_W-1:0] r_shamt;
  shift_op_t          r_op;
  logic               r_sign;

  always_comb begin
    w_shifted = i_data;
    if (i_shamt[STAGE_IDX]) begin
      case (i_op)
        SLL:     w_shifted = i_data << DIST;
        SRL:     w_shifted = i_data >> DIST;
        // SRA fills from the operand's original MSB, not the current partial result.
        SRA:     w_shifted = {{DIST{i_sign}}, i_data[DATA_W-1:DIST]};
        ROL:     w_shifted = {i_data[DATA_W-1-DIST:0], i_data[DATA_W-1 -: DIST]};
        default: w_shifted = i_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_shamt <= '0;
      r_op    <= SLL;
      r_sign  <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data  <= w_shifted;
        r_shamt <= i_shamt;
        r_op    <= i_op;
        r_sign  <= i_sign;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_shamt = r_shamt;
  assign o_op    = r_op;
  assign o_sign  = r_sign;

endmodule

// File: rtl/log_shift_pipe.sv
// Pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROL), one stage per shift-amount bit,
// with valid/ready flow control and an in-flight occupancy count.
module log_shift_pipe
  import log_shift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic [SHAMT_W-1:0]           in_shamt,
  input  shift_op_t                    in_op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(SHAMT_W+1)-1:0] occupancy
);

  localparam int                OCC_W   = $clog2(SHAMT_W + 1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(SHAMT_W);

  // Index 0 is the pipe input; index k+1 is the register output of stage k.
  logic [DATA_W-1:0]  w_data  [SHAMT_W+1];
  logic [SHAMT_W-1:0] w_shamt [SHAMT_W+1];
  shift_op_t          w_op    [SHAMT_W+1];
  logic [SHAMT_W:0]   w_valid;
  logic [SHAMT_W:0]   w_sign;
  logic [SHAMT_W-1:0] w_en;
  logic               w_accept;
  logic               w_emit;
  logic               w_unused_tail;
  logic [OCC_W-1:0]   r_occ;

  assign w_data[0]  = in_data;
  assign w_shamt[0] = in_shamt;
  assign w_op[0]    = in_op;
  assign w_valid[0] = in_valid;
  assign w_sign[0]  = in_data[DATA_W-1];

  // Ready ripples back from the sink so bubbles anywhere in the pipe get filled.
  always_comb begin
    w_en            = '0;
    w_en[SHAMT_W-1] = !w_valid[SHAMT_W] || out_ready;
    for (int k = SHAMT_W - 2; k >= 0; k--) begin
      w_en[k] = !w_valid[k+1] || w_en[k+1];
    end
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    log_shift_stage #(
      .DATA_W    (DATA_W),
      .SHAMT_W   (SHAMT_W),
      .STAGE_IDX (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_en[k]),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .i_shamt (w_shamt[k]),
      .i_op    (w_op[k]),
      .i_sign  (w_sign[k]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .o_shamt (w_shamt[k+1]),
      .o_op    (w_op[k+1]),
      .o_sign  (w_sign[k+1])
    );
  end

  assign w_unused_tail = ^{w_shamt[SHAMT_W], w_op[SHAMT_W], w_sign[SHAMT_W]};

  assign in_ready  = w_en[0];
  assign out_valid = w_valid[SHAMT_W];
  assign out_data  = w_data[SHAMT_W];
  assign w_accept  = in_valid && in_ready;
  assign w_emit    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (w_accept && !w_emit && r_occ != OCC_MAX) begin
      r_occ <= r_occ + 1'b1;
    end else if (!w_accept && w_emit && r_occ != '0) begin
      r_occ <= r_occ - 1'b1;
    end
  end

  assign occupancy = r_occ;

  a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

  a_occ_bound : assert property (@(posedge clk) disable iff (!rst_n)
    r_occ <= OCC_MAX);

endmodule

// File: tb/tb_log_shift_pipe.sv
// Scoreboard bench for log_shift_pipe: directed ops, back-to-back, backpressure, reset, random flow.
module tb_log_shift_pipe;
  import log_shift_pkg::*;

  localparam int DW = 32;
  localparam int SW = 5;
  localparam int OW = 3;
  localparam int N_RAND = 10000;

  typedef struct {
    logic [DW-1:0] exp;
    int            acc;
    bit            lat;
    bit            b2b;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_shamt;
  shift_op_t     in_op;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [OW-1:0] occupancy;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            n_emit = 0;
  int            last_emit = 0;
  bit            tb_acc = 1'b0;
  bit            use_dir = 1'b0;
  bit            chk_lat = 1'b0;
  bit            in_b2b = 1'b0;
  bit            prev_b2b = 1'b0;
  logic [DW-1:0] dir_exp = '0;
  sb_t           q[$];

  always #5 clk = ~clk;

  log_shift_pipe #(.DATA_W(DW), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Bit-by-bit source selection, written independently of any shifter structure.
  function automatic logic [DW-1:0] tb_ref(input logic [DW-1:0] d, input int sh, input shift_op_t op);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) begin
      case (op)
        SLL:     r[i] = (i >= sh) ? d[i-sh] : 1'b0;
        SRL:     r[i] = (i + sh < DW) ? d[i+sh] : 1'b0;
        SRA:     r[i] = (i + sh < DW) ? d[i+sh] : d[DW-1];
        default: r[i] = d[(i - sh + DW) % DW];
      endcase
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are decided by the values stable at the falling edge before each rising edge.
  always @(negedge clk) begin
    sb_t e;
    tb_acc = 1'b0;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        tb_acc = 1'b1;
        e.exp = use_dir ? dir_exp : tb_ref(in_data, int'(in_shamt), in_op);
        e.acc = cyc;
        e.lat = chk_lat;
        e.b2b = in_b2b;
        q.push_back(e);
      end
      if (out_valid && out_ready) begin
        n_emit++;
        if (q.size() == 0) begin
          check_eq("spurious_out", q.size(), 1);
        end else begin
          e = q.pop_front();
          check_eq("result", out_data, e.exp);
          if (e.lat) check_eq("latency", cyc - e.acc, SW);
          if (e.b2b && prev_b2b) check_eq("b2b_gap", cyc - last_emit, 1);
          prev_b2b  = e.b2b;
          last_emit = cyc;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input int sh, input shift_op_t op);
    int guard;
    in_data  = d;
    in_shamt = SW'(sh);
    in_op    = op;
    in_valid = 1'b1;
    guard    = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (!tb_acc && guard < 50);
    in_valid = 1'b0;
    check_eq("send_acc", 32'(tb_acc), 1);
  endtask

  task automatic wait_drain(input string tag);
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq(tag, q.size(), 0);
  endtask

  task automatic directed(input logic [DW-1:0] d, input int sh, input shift_op_t op,
                          input logic [DW-1:0] exp, input string tag);
    use_dir = 1'b1;
    chk_lat = 1'b1;
    dir_exp = exp;
    send(d, sh, op);
    wait_drain(tag);
    use_dir = 1'b0;
    chk_lat = 1'b0;
  endtask

  task automatic rand_operand();
    in_data  = $urandom;
    in_shamt = SW'($urandom_range(DW - 1));
    in_op    = shift_op_t'($urandom_range(3));
  endtask

  initial begin
    int acc;
    int e0;
    int sent;
    bit have_hold;
    logic [DW-1:0] hold;

    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = SLL;
    out_ready = 1'b1;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_occupancy", 32'(occupancy), 0);
    check_eq("rst_in_ready", 32'(in_ready), 1);

    // Directed single operations
    directed(32'h0000_0001, 31, SLL, 32'h8000_0000, "sll31");
    directed(32'h8000_0000, 4, SRL, 32'h0800_0000, "srl4");
    directed(32'h8000_0000, 4, SRA, 32'hF800_0000, "sra4");
    directed(32'h1234_5678, 8, ROL, 32'h3456_7812, "rol8");
    directed(32'hDEAD_BEEF, 0, SLL, 32'hDEAD_BEEF, "sll0");
    directed(32'hDEAD_BEEF, 0, SRL, 32'hDEAD_BEEF, "srl0");
    directed(32'hDEAD_BEEF, 0, SRA, 32'hDEAD_BEEF, "sra0");
    directed(32'hDEAD_BEEF, 0, ROL, 32'hDEAD_BEEF, "rol0");

    // Back-to-back stream
    in_b2b    = 1'b1;
    out_ready = 1'b1;
    rand_operand();
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_eq("b2b_acc", 32'(tb_acc), 1);
      if (i == 9) begin
        check_eq("b2b_occupancy", 32'(occupancy), SW);
        check_eq("b2b_in_ready", 32'(in_ready), 1);
      end
      if (i < 19) rand_operand();
      else in_valid = 1'b0;
    end
    in_b2b = 1'b0;
    wait_drain("b2b_drain");

    // Backpressure
    e0        = n_emit;
    acc       = 0;
    have_hold = 1'b0;
    hold      = '0;
    out_ready = 1'b0;
    rand_operand();
    in_valid  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (tb_acc) begin
        acc++;
        rand_operand();
      end
      if (acc >= SW) begin
        check_eq("bp_in_ready", 32'(in_ready), 0);
        check_eq("bp_occupancy", 32'(occupancy), SW);
        check_eq("bp_out_valid", 32'(out_valid), 1);
        if (!have_hold) begin
          hold      = out_data;
          have_hold = 1'b1;
        end else begin
          check_eq("bp_stable", out_data, hold);
        end
      end
    end
    in_valid = 1'b0;
    check_eq("bp_accepts", acc, SW);
    out_ready = 1'b1;
    wait_drain("bp_drain");
    @(posedge clk); #1;
    check_eq("bp_emits", n_emit - e0, SW);

    // Reset with operands in flight
    rand_operand();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rand_operand();
    end
    in_valid = 1'b0;
    check_eq("pre_rst_occupancy", 32'(occupancy), 3);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_occupancy", 32'(occupancy), 0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 1);
    q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    e0 = n_emit;
    repeat (10) @(posedge clk);
    #1;
    check_eq("no_ghost_emit", n_emit - e0, 0);
    check_eq("post_rst_out_valid", 32'(out_valid), 0);

    // Random valid/ready toggling
    e0       = n_emit;
    sent     = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 60000 && (n_emit - e0) < N_RAND; c++) begin
      @(posedge clk); #1;
      if (tb_acc) sent++;
      if (!in_valid || tb_acc) begin
        if (sent < N_RAND && $urandom_range(9) < 7) begin
          rand_operand();
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(9) < 7);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("rand_count", n_emit - e0, N_RAND);
    wait_drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/log_shift_pipe.md
Name: log_shift_pipe

Overview:
- Pipelined logarithmic barrel shifter; the datapath stage the LOG_SHIFT testbench drives and checks.
- One register stage per shift-amount bit, with valid/ready flow control on input and output.
- Sits between an operand source (upstream valid/ready producer) and a result sink (downstream consumer/checker).
- Sustains one result per cycle when the sink never stalls.

Parameters:
- DATA_W, 32, operand/result width; power of two, >= 4.
- SHAMT_W, $clog2(DATA_W), shift-amount width; equals the number of pipeline stages (5 at default).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  stage 0 can accept this cycle.
- in_data  input  DATA_W  operand.
- in_shamt  input  SHAMT_W  shift amount, 0..DATA_W-1.
- in_op  input  2  shift_op_t: SLL=0, SRL=1, SRA=2, ROL=3.
- out_valid  output  1  result available.
- out_ready  input  1  sink accepts result.
- out_data  output  DATA_W  shifted result.
- occupancy  output  $clog2(SHAMT_W+1)  number of valid stages in flight.

Behaviour:
- Reset (async assert, sync-free deassert): all stage valids=0, out_valid=0, out_data=0, occupancy=0, in_ready=1 at the first cycle after release. In-flight operands are discarded. No partial result ever emerges.
- Stage k (k=0..SHAMT_W-1) conditionally shifts by 2^k when shamt bit k is 1 (LSB first), then registers data, remaining shamt, op, sign bit and valid.
- Op rules:
  - SLL fills zeros from the LSB.
  - SRL fills zeros from the MSB.
  - SRA fills with the original operand MSB, captured at stage 0 and carried down the pipe.
  - ROL wraps the MSBs into the LSBs.
- Shift amount 0 passes data unchanged for every op.
- Latency: an operand accepted at edge N (in_valid && in_ready) shows out_valid=1 with its result after edge N+SHAMT_W-1, i.e. SHAMT_W cycles of pipeline including the output register. The last stage register drives out_data/out_valid directly.
- Flow control:
  - Stage k advances when !valid[k+1] || advance[k+1].
  - The last stage advances when !out_valid || out_ready.
  - in_ready = !valid[0] || advance[0]. The ready chain is combinational; bubbles collapse.
  - Stalled stages hold data and valid stable.
  - While out_valid && !out_ready, out_data must not change.
- Simultaneous accept and emit in the same cycle is legal; occupancy is unchanged.
- occupancy += accept, -= emit. It saturates at SHAMT_W and never exceeds it by construction.
- in_data/in_shamt/in_op are ignored when !in_valid or !in_ready. Unused stage payloads may hold stale values, but their valid stays 0.
- No combinational path from in_* to out_*. The only combinational path from out_ready is to in_ready and the advance signals.

Decomposition:
- Package log_shift_pkg holds:
  - typedef enum logic [1:0] shift_op_t {SLL, SRL, SRA, ROL};
  - the stage payload struct {data, shamt, op, sign};
  - the function shift_ref(data, shamt, op), shared by RTL assertions and the bench scoreboard.
- The bench's existing pass/fail statistics and verbosity printing remain in the testbench utility package; nothing bench-side enters log_shift_pkg beyond shift_ref.
- Sub-module log_shift_stage: parameter STAGE_IDX; performs the conditional 2^STAGE_IDX shift plus the register/hold logic. Instantiated SHAMT_W times by generate.

Test Plan:
- Reset, then idle: out_valid=0, out_data=0, occupancy=0, in_ready=1. Assert rst_n=0 mid-stream with 3 operands in flight: all valids clear immediately, and no result emerges after release.
- Single ops, out_ready=1, DATA_W=32:
  - SLL 0x0000_0001 by 31 -> 0x8000_0000.
  - SRL 0x8000_0000 by 4 -> 0x0800_0000.
  - SRA 0x8000_0000 by 4 -> 0xF800_0000.
  - ROL 0x1234_5678 by 8 -> 0x3456_7812.
  - Each result appears exactly 5 cycles after accept.
- Shift by 0 for all four ops on 0xDEAD_BEEF -> 0xDEAD_BEEF.
- Back-to-back: 20 random operands on consecutive cycles with out_ready=1 -> 20 results on consecutive cycles, in order, each equal to shift_ref; occupancy=5 at steady state.
- Backpressure: hold out_ready=0 for 8 cycles while streaming. Required response:
  - in_ready drops after 5 accepts;
  - occupancy=5;
  - out_data stays stable throughout the stall;
  - on release, results drain in order with no loss or duplicate.
- Randomised valid/ready toggling for 10k transactions: scoreboard pass count 10k, fail count 0.
